// File: rtl/move_input_if.sv
`default_nettype none
// ============================================================================
// Module      : move_input_if
// Description : Bundle of the move input conditioner's data and handshake lines.
//               master - drives raw switch lines and ack, observes the results
//                        (the core's input selector / the raw pad side).
//               slave  - the conditioner itself.
//               Signals:
//                 raw_in     raw asynchronous move lines
//                 ack        single-cycle "move taken" pulse from the consumer
//                 move_out   latched move code, stable while move_valid=1
//                 move_valid move_out holds an unconsumed move
//                 stable_out current debounced level of raw_in
//                 overrun    sticky flag: a committed move was dropped
// Revision    : 1.0 - initial release
// ============================================================================
interface move_input_if #(
    parameter int WIDTH = 7
);
    logic [WIDTH-1:0] raw_in;
    logic             ack;
    logic [WIDTH-1:0] move_out;
    logic             move_valid;
    logic [WIDTH-1:0] stable_out;
    logic             overrun;

    modport master (
        output raw_in,
        output ack,
        input  move_out,
        input  move_valid,
        input  stable_out,
        input  overrun
    );

    modport slave (
        input  raw_in,
        input  ack,
        output move_out,
        output move_valid,
        output stable_out,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/move_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : move_input_conditioner
// Description : Synchronises and debounces the raw move lines, then latches
//               each new non-zero debounced move into a holding register with
//               a valid/ack handshake, so every move is read exactly once.
//               Ports:
//                 clk    system clock, all state on the rising edge
//                 rst    synchronous active-high reset
//                 bus_if slave side of move_input_if
//                        (raw_in, ack in; move_out, move_valid,
//                         stable_out, overrun out)
// Revision    : 1.0 - initial release
// ============================================================================
module move_input_conditioner #(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    move_input_if.slave       bus_if
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // Two-flop synchroniser; only sync2 is used downstream.
    logic [WIDTH-1:0] sync1_q, sync2_q;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] cand_q,   cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] move_q,   move_d;
    logic             valid_q,  valid_d;
    logic             ovr_q,    ovr_d;

    logic             commit;
    logic             new_move;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            move_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= bus_if.raw_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            move_q   <= move_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        move_d   = move_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        commit   = 1'b0;
        new_move = 1'b0;

        // Debounce: one counter for the whole vector; any change in any bit
        // restarts the settle window.
        case (state_q)
            ST_STABLE: begin
                if (sync2_q != cand_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit   = 1'b1;
                    stable_d = cand_q;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase

        // A glitch that settles back to the old level, or a release to all
        // zeros, is not a move.
        new_move = commit && (cand_q != stable_q) && (cand_q != '0);

        if (new_move) begin
            if (!valid_q) begin
                move_d  = cand_q;
                valid_d = 1'b1;
            end else if (!bus_if.ack) begin
                ovr_d = 1'b1;
            end else begin
                // Old move consumed this very edge; the new one replaces it.
                move_d = cand_q;
            end
        end else if (bus_if.ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign bus_if.move_out   = move_q;
    assign bus_if.move_valid = valid_q;
    assign bus_if.stable_out = stable_q;
    assign bus_if.overrun    = ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_move_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_input_conditioner
// Description : Directed bench for move_input_conditioner. A run-length model
//               of the debounce and the move handshake predicts every output
//               each cycle; literal checks at key edges pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_input_conditioner;
    localparam int WIDTH = 7;
    localparam int DEB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_input_if #(.WIDTH(WIDTH)) bus_if ();

    move_input_conditioner #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bus_if.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // sync2 value seen at an edge is the raw value sampled two edges earlier.
    // A value commits when it has been seen in DEB+1 consecutive edges.
    logic [WIDTH-1:0] m_s1, m_s2, m_runv, m_stable, m_move;
    int               m_runlen;
    bit               m_valid, m_ov;
    bit               model_ok = 0;

    always @(posedge clk) begin
        bit commit, newm;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_runv = '0; m_runlen = DEB + 2;
            m_stable = '0; m_move = '0; m_valid = 0; m_ov = 0;
            model_ok = 1;
        end else begin
            if (m_s2 == m_runv) begin
                if (m_runlen < DEB + 2) m_runlen++;
            end else begin
                m_runv   = m_s2;
                m_runlen = 1;
            end
            commit = (m_runlen == DEB + 1);
            newm   = commit && (m_runv != m_stable) && (m_runv != 0);
            if (newm) begin
                if (!m_valid) begin m_move = m_runv; m_valid = 1; end
                else if (!bus_if.ack) m_ov = 1;
                else m_move = m_runv;
            end else if (bus_if.ack && m_valid) begin
                m_valid = 0;
            end
            if (commit) m_stable = m_runv;
            m_s2 = m_s1;
            m_s1 = bus_if.raw_in;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model move_out",   32'(bus_if.move_out),   32'(m_move));
            chk("model move_valid", 32'(bus_if.move_valid), 32'(m_valid));
            chk("model stable_out", 32'(bus_if.stable_out), 32'(m_stable));
            chk("model overrun",    32'(bus_if.overrun),    32'(m_ov));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        bus_if.ack = 1'b1;
        step(1);
        bus_if.ack = 1'b0;
    endtask

    initial begin
        bus_if.raw_in = 7'h55;
        bus_if.ack    = 1'b0;

        // 1: reset held two cycles with raw=55
        step(2);
        chk("reset valid",  32'(bus_if.move_valid), 32'h0);
        chk("reset move",   32'(bus_if.move_out),   32'h0);
        chk("reset stable", 32'(bus_if.stable_out), 32'h0);
        chk("reset ovr",    32'(bus_if.overrun),    32'h0);
        rst = 1'b0;
        step(6);
        chk("t1 pre-commit valid",  32'(bus_if.move_valid), 32'h0);
        chk("t1 pre-commit stable", 32'(bus_if.stable_out), 32'h0);
        step(1);
        chk("t1 commit move", 32'(bus_if.move_out), 32'h55);
        ack_pulse();
        chk("t1 ack clears", 32'(bus_if.move_valid), 32'h0);
        chk("t1 move kept",  32'(bus_if.move_out),   32'h55);

        // 2: 0 -> 12, commit on the 7th edge
        bus_if.raw_in = 7'h00;
        step(8);
        chk("t2 release no move", 32'(bus_if.move_valid), 32'h0);
        chk("t2 release stable",  32'(bus_if.stable_out), 32'h0);
        bus_if.raw_in = 7'h12;
        step(6);
        chk("t2 edge6 valid", 32'(bus_if.move_valid), 32'h0);
        step(1);
        chk("t2 edge7 valid",  32'(bus_if.move_valid), 32'h1);
        chk("t2 edge7 move",   32'(bus_if.move_out),   32'h12);
        chk("t2 edge7 stable", 32'(bus_if.stable_out), 32'h12);
        ack_pulse();
        bus_if.raw_in = 7'h00;
        step(8);

        // 3: bouncing 12/00 every 2 cycles never commits
        for (int i = 0; i < 10; i++) begin
            bus_if.raw_in = (i % 2 == 0) ? 7'h12 : 7'h00;
            step(2);
            chk("t3 bounce valid",  32'(bus_if.move_valid), 32'h0);
            chk("t3 bounce stable", 32'(bus_if.stable_out), 32'h0);
        end
        bus_if.raw_in = 7'h00;
        step(10);
        chk("t3 end valid", 32'(bus_if.move_valid), 32'h0);

        // 4: overrun when a second move arrives without ack
        bus_if.raw_in = 7'h03;
        step(8);
        chk("t4 first move", 32'(bus_if.move_out), 32'h03);
        bus_if.raw_in = 7'h05;
        step(8);
        chk("t4 overrun",    32'(bus_if.overrun),    32'h1);
        chk("t4 move held",  32'(bus_if.move_out),   32'h03);
        chk("t4 stable",     32'(bus_if.stable_out), 32'h05);
        ack_pulse();
        chk("t4 ack clears", 32'(bus_if.move_valid), 32'h0);

        // 5: ack on the exact commit edge of the new move
        rst = 1'b1;
        bus_if.raw_in = 7'h00;
        step(2);
        rst = 1'b0;
        chk("t5 ovr cleared", 32'(bus_if.overrun), 32'h0);
        bus_if.raw_in = 7'h03;
        step(8);
        chk("t5 first move", 32'(bus_if.move_out), 32'h03);
        bus_if.raw_in = 7'h05;
        step(6);
        ack_pulse();
        chk("t5 move replaced", 32'(bus_if.move_out),   32'h05);
        chk("t5 valid stays",   32'(bus_if.move_valid), 32'h1);
        chk("t5 no overrun",    32'(bus_if.overrun),    32'h0);

        // 6: reset mid-settle with a move pending
        bus_if.raw_in = 7'h21;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6 rst valid",  32'(bus_if.move_valid), 32'h0);
        chk("t6 rst move",   32'(bus_if.move_out),   32'h0);
        chk("t6 rst stable", 32'(bus_if.stable_out), 32'h0);
        step(6);
        chk("t6 edge6 valid", 32'(bus_if.move_valid), 32'h0);
        step(1);
        chk("t6 recommit valid", 32'(bus_if.move_valid), 32'h1);
        chk("t6 recommit move",  32'(bus_if.move_out),   32'h21);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
